// File: rtl/f_pc_npc_pkg.sv
// Shared definitions for the fetch-stage PC / next-PC slice:
// next-PC operation encodings and the default reset PC.
package f_pc_npc_pkg;

    typedef enum logic [1:0] {
        NPC_PC4 = 2'd0,
        NPC_B   = 2'd1,
        NPC_J   = 2'd2,
        NPC_JR  = 2'd3
    } npc_op_e;

    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_3000;

    // Sign-extended, word-scaled branch offset.
    function automatic logic [31:0] branch_offset(input logic [15:0] imm16);
        return {{14{imm16[15]}}, imm16, 2'b00};
    endfunction

endpackage

// File: rtl/f_pc_npc_sel.sv
// Combinational next-PC selector (f_npc_sel).
// Optional macro NPC_ALIGN_CHK_EN: jr/jalr targets are forced word-aligned.
import f_pc_npc_pkg::*;

module f_npc_sel (
    input  logic [1:0]  NPCOp,
    input  logic        CMP_Result,
    input  logic [31:0] F_PC,
    input  logic [31:0] D_PC,
    input  logic [15:0] D_Imm16,
    input  logic [25:0] D_Imm26,
    input  logic [31:0] D_RsVal,
    output logic [31:0] NPC
);

    npc_op_e     op;
    logic [31:0] seq_pc;
    logic [31:0] branch_pc;
    logic [31:0] jump_pc;
    logic [31:0] reg_pc;

    assign op        = npc_op_e'(NPCOp);
    assign seq_pc    = F_PC + 32'd4;
    assign branch_pc = D_PC + 32'd4 + branch_offset(D_Imm16);
    assign jump_pc   = {D_PC[31:28], D_Imm26, 2'b00};

`ifdef NPC_ALIGN_CHK_EN
    assign reg_pc = {D_RsVal[31:2], 2'b00};
`else
    assign reg_pc = D_RsVal;
`endif

    // Pick the next fetch address; not-taken branches fall through to F_PC+4.
    always_comb begin
        NPC = seq_pc;
        case (op)
            NPC_B:   NPC = CMP_Result ? branch_pc : seq_pc;
            NPC_J:   NPC = jump_pc;
            NPC_JR:  NPC = reg_pc;
            default: NPC = seq_pc;
        endcase
    end

endmodule

// File: rtl/f_pc_npc.sv
// Fetch-stage PC register with stall/reset handling and next-PC selection.
// Delay-slot semantics: the instruction in F always proceeds; no flush.
// Optional macro NPC_ALIGN_CHK_EN: sticky PC_Err on misaligned jr/jalr target.
import f_pc_npc_pkg::*;

module f_pc_npc #(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic [1:0]  NPCOp,
    input  logic        CMP_Result,
    input  logic [31:0] D_PC,
    input  logic [15:0] D_Imm16,
    input  logic [25:0] D_Imm26,
    input  logic [31:0] D_RsVal,
    output logic [31:0] F_PC,
    output logic [31:0] D_PC8,
    output logic [31:0] NPC,
    output logic        PC_Err
);

    f_npc_sel u_npc_sel (
        .NPCOp      (NPCOp),
        .CMP_Result (CMP_Result),
        .F_PC       (F_PC),
        .D_PC       (D_PC),
        .D_Imm16    (D_Imm16),
        .D_Imm26    (D_Imm26),
        .D_RsVal    (D_RsVal),
        .NPC        (NPC)
    );

    assign D_PC8 = D_PC + 32'd8;

    // PC register: reset beats stall, stall beats any redirect.
    always_ff @(posedge clk) begin
        if (reset) begin
            F_PC <= RESET_PC;
        end else if (!stall) begin
            F_PC <= NPC;
        end
    end

`ifdef NPC_ALIGN_CHK_EN
    logic misaligned_jr;

    assign misaligned_jr = (npc_op_e'(NPCOp) == NPC_JR) && (D_RsVal[1:0] != 2'b00);

    // Sticky misalignment flag, cleared only by reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            PC_Err <= 1'b0;
        end else if (!stall && misaligned_jr) begin
            PC_Err <= 1'b1;
        end
    end
`else
    assign PC_Err = 1'b0;
`endif

endmodule

// File: tb/tb_f_pc_npc.sv
// Self-checking bench for f_pc_npc: directed cases plus randomized traffic
// against an arithmetic reference model. Honours NPC_ALIGN_CHK_EN.
module tb_f_pc_npc;

    localparam logic [31:0] RST_PC = 32'h0000_3000;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall;
    logic [1:0]  NPCOp;
    logic        CMP_Result;
    logic [31:0] D_PC;
    logic [15:0] D_Imm16;
    logic [25:0] D_Imm26;
    logic [31:0] D_RsVal;
    logic [31:0] F_PC;
    logic [31:0] D_PC8;
    logic [31:0] NPC;
    logic        PC_Err;

    int unsigned errors = 0;
    int unsigned checks = 0;

    logic [31:0] exp_pc;
    logic        exp_err;

    f_pc_npc #(.RESET_PC(RST_PC)) dut (
        .clk        (clk),
        .reset      (reset),
        .stall      (stall),
        .NPCOp      (NPCOp),
        .CMP_Result (CMP_Result),
        .D_PC       (D_PC),
        .D_Imm16    (D_Imm16),
        .D_Imm26    (D_Imm26),
        .D_RsVal    (D_RsVal),
        .F_PC       (F_PC),
        .D_PC8      (D_PC8),
        .NPC        (NPC),
        .PC_Err     (PC_Err)
    );

    always #5 clk = ~clk;

`ifdef NPC_ALIGN_CHK_EN
    localparam bit ALIGN_CHK = 1'b1;
`else
    localparam bit ALIGN_CHK = 1'b0;
`endif

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h", tag, got, want);
        end
    endtask

    // Reference next PC from the architectural rules, plain arithmetic.
    function automatic logic [31:0] model_npc(input logic [1:0] op, input logic cmp,
                                              input logic [31:0] fpc, input logic [31:0] dpc,
                                              input logic [15:0] i16, input logic [25:0] i26,
                                              input logic [31:0] rs);
        logic [31:0] off;
        off = {{16{i16[15]}}, i16};
        case (op)
            2'd1:    return cmp ? (dpc + 32'd4 + off * 32'd4) : (fpc + 32'd4);
            2'd2:    return (dpc & 32'hF000_0000) | ({6'd0, i26} * 32'd4);
            2'd3:    return ALIGN_CHK ? (rs & ~32'd3) : rs;
            default: return fpc + 32'd4;
        endcase
    endfunction

    // Drive one cycle of inputs, check the combinational outputs, clock, check state.
    task automatic apply(input logic rst, input logic stl, input logic [1:0] op,
                         input logic cmp, input logic [31:0] dpc, input logic [15:0] i16,
                         input logic [25:0] i26, input logic [31:0] rs, input bit chk_comb);
        logic [31:0] want_npc;
        reset = rst; stall = stl; NPCOp = op; CMP_Result = cmp;
        D_PC = dpc; D_Imm16 = i16; D_Imm26 = i26; D_RsVal = rs;
        #1;
        want_npc = model_npc(op, cmp, exp_pc, dpc, i16, i26, rs);
        if (chk_comb) begin
            check("npc", NPC, want_npc);
            check("d_pc8", D_PC8, dpc + 32'd8);
        end
        if (rst) begin
            exp_pc  = RST_PC;
            exp_err = 1'b0;
        end else if (!stl) begin
            if (ALIGN_CHK && op == 2'd3 && rs[1:0] != 2'b00) exp_err = 1'b1;
            exp_pc = want_npc;
        end
        @(posedge clk);
        #1;
        check("f_pc", F_PC, exp_pc);
        check("pc_err", {31'd0, PC_Err}, {31'd0, exp_err});
    endtask

    task automatic pc4(input int unsigned n);
        for (int unsigned k = 0; k < n; k++)
            apply(1'b0, 1'b0, 2'd0, 1'b0, 32'h0, 16'h0, 26'h0, 32'h0, 1'b1);
    endtask

    task automatic do_reset();
        apply(1'b1, 1'b0, 2'd0, 1'b0, 32'h0, 16'h0, 26'h0, 32'h0, 1'b0);
    endtask

    initial begin
        exp_pc  = 'x;
        exp_err = 1'b0;
        @(posedge clk);
        #1;

        // Reset then sequential fetch.
        do_reset();
        check("reset_pc", F_PC, 32'h3000);
        pc4(3);
        check("seq_300c", F_PC, 32'h300C);

        // Backward branch taken / not taken from F_PC=0x3008, D_PC=0x3004.
        do_reset(); pc4(2);
        apply(1'b0, 1'b0, 2'd1, 1'b1, 32'h3004, 16'hFFFE, 26'h0, 32'h0, 1'b1);
        check("b_taken", F_PC, 32'h3000);
        do_reset(); pc4(2);
        apply(1'b0, 1'b0, 2'd1, 1'b0, 32'h3004, 16'hFFFE, 26'h0, 32'h0, 1'b1);
        check("b_not_taken", F_PC, 32'h300C);

        // Jump with link value.
        apply(1'b0, 1'b0, 2'd2, 1'b0, 32'h3010, 16'h0, 26'h0000C10, 32'h0, 1'b1);
        check("j_target", F_PC, 32'h3040);
        check("j_link", D_PC8, 32'h3018);

        // Stall held two edges over a taken branch, then released once.
        do_reset(); pc4(2);
        apply(1'b0, 1'b1, 2'd1, 1'b1, 32'h3004, 16'h0010, 26'h0, 32'h0, 1'b1);
        check("stall_hold1", F_PC, 32'h3008);
        apply(1'b0, 1'b1, 2'd1, 1'b1, 32'h3004, 16'h0010, 26'h0, 32'h0, 1'b1);
        check("stall_hold2", F_PC, 32'h3008);
        apply(1'b0, 1'b0, 2'd1, 1'b1, 32'h3004, 16'h0010, 26'h0, 32'h0, 1'b1);
        check("stall_release", F_PC, 32'h3048);
        pc4(1);
        check("stall_once", F_PC, 32'h304C);

        // Misaligned jr target, stickiness of the error flag.
        apply(1'b0, 1'b0, 2'd3, 1'b0, 32'h3044, 16'h0, 26'h0, 32'h3006, 1'b1);
        check("jr_target", F_PC, ALIGN_CHK ? 32'h3004 : 32'h3006);
        check("jr_err", {31'd0, PC_Err}, {31'd0, ALIGN_CHK});
        pc4(2);
        check("jr_err_sticky", {31'd0, PC_Err}, {31'd0, ALIGN_CHK});

        // Reset dominates stall and a taken branch.
        apply(1'b1, 1'b1, 2'd1, 1'b1, 32'h3004, 16'hFFFE, 26'h0, 32'h0, 1'b1);
        check("rst_over_stall", F_PC, 32'h3000);
        check("rst_clears_err", {31'd0, PC_Err}, 32'd0);

        // Wrap at top of address space.
        apply(1'b0, 1'b0, 2'd3, 1'b0, 32'h0, 16'h0, 26'h0, 32'hFFFF_FFFC, 1'b1);
        pc4(1);
        check("wrap", F_PC, 32'h0000_0000);

        // Randomized traffic against the model.
        for (int unsigned n = 0; n < 400; n++) begin
            logic [31:0] rs;
            rs = $urandom;
            if ($urandom_range(0, 1) == 0) rs[1:0] = 2'b00;
            apply(($urandom_range(0, 31) == 0), ($urandom_range(0, 3) == 0),
                  2'($urandom_range(0, 3)), 1'($urandom), $urandom,
                  16'($urandom), 26'($urandom), rs, 1'b1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Hard time limit so the run always terminates.
    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule

// File: doc/f_pc_npc.md
Name: f_pc_npc

Overview:
- Fetch-stage PC register with next-PC selection. It consumes CMP_Result from the D-stage comparator, together with the decoded D-stage jump and branch fields.
- It produces the PC for instruction memory each cycle.
- MIPS delay-slot semantics apply: branches and jumps resolve in D, and the instruction already in F (the delay slot) always proceeds.
- It sits between the hazard/stall unit, the D-stage decoder/comparator, and IM.

Parameters:
- RESET_PC, 32'h0000_3000, PC value loaded on reset.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- stall  input  1  from hazard unit; 1 = hold PC.
- NPCOp  input  2  D-stage next-PC operation: PC4 / B / J / JR.
- CMP_Result  input  1  D-stage branch-taken result from the comparator.
- D_PC  input  32  PC of the instruction currently in D.
- D_Imm16  input  16  branch offset field of the D instruction.
- D_Imm26  input  26  jump index field of the D instruction.
- D_RsVal  input  32  forwarded rs value, used as the jr/jalr target.
- F_PC  output  32  current fetch PC, driving the IM address.
- D_PC8  output  32  D_PC+8, the link value for jal/jalr.
- NPC  output  32  combinational next PC (for debug/bench).
- PC_Err  output  1  misalignment flag; only meaningful with the optional feature.

Behaviour:
- Reset (synchronous, active-high):
  - F_PC <= RESET_PC and PC_Err <= 0.
  - Reset overrides stall and any redirect.
  - A reset asserted in mid-stream takes effect at the next rising edge.
- NPC selection (combinational; all arithmetic is 32-bit modulo 2^32, carries discarded):
  - PC4: NPC = F_PC+4.
  - B: NPC = CMP_Result ? D_PC+4+(sext(D_Imm16)<<2) : F_PC+4.
  - J (j/jal): NPC = {D_PC[31:28], D_Imm26, 2'b00}.
  - JR (jr/jalr): NPC = D_RsVal.
- Update rule:
  - At each rising edge with reset=0 and stall=0: F_PC <= NPC.
  - With stall=1: F_PC is held.
- Stall priority:
  - A stall dominates a redirect. The stalled D instruction is re-evaluated in a later cycle, so the redirect is taken once, on the first non-stalled cycle.
- Delay slot:
  - While a branch or jump sits in D, F holds D_PC+4 (the delay slot).
  - The fall-through value F_PC+4 equals D_PC+8.
  - No flush is generated.
- D_PC8 = D_PC+8, combinational and always valid.
- Non-branch, not-taken, and unrecognised NPCOp encodings all take the PC4 path.
- F_PC wraps from 32'hFFFF_FFFC to 32'h0000_0000 with no flag.
- Latency:
  - NPC is combinational in the same cycle.
  - F_PC reflects a redirect one edge after the branch/jump is resolved in D.

Optional Feature:
- Macro: NPC_ALIGN_CHK_EN.
- Defined:
  - When NPCOp=JR, D_RsVal[1:0]!=0, and stall=0, PC_Err is set and stays set until reset (sticky).
  - The loaded F_PC is {D_RsVal[31:2], 2'b00}.
- Undefined:
  - D_RsVal is used unmodified.
  - PC_Err is tied to 0.

Decomposition:
- Shared include macro.v holds:
  - NPCOp encodings: NPC_PC4=2'd0, NPC_B=2'd1, NPC_J=2'd2, NPC_JR=2'd3.
  - The default RESET_PC constant.
- One combinational sub-module, f_npc_sel: takes NPCOp, CMP_Result, F_PC, D_PC, the immediate fields and D_RsVal, and outputs NPC.
- The top level holds the F_PC register, the stall/reset logic and the PC_Err flag.

Test Plan:
- Reset, then 3 edges with NPCOp=PC4 and stall=0 -> F_PC = 0x3000, 0x3004, 0x3008, 0x300C.
- D_PC=0x3004, F_PC=0x3008, NPCOp=B, D_Imm16=0xFFFE -> CMP_Result=1: next F_PC=0x3000. CMP_Result=0: next F_PC=0x300C.
- D_PC=0x3010, NPCOp=J, D_Imm26=26'h0000C10 -> next F_PC=0x3040. D_PC8=0x3018.
- NPCOp=B, CMP_Result=1, stall held 2 cycles, then released -> F_PC unchanged for 2 edges, then loads the target exactly once.
- NPCOp=JR, D_RsVal=0x3006:
  - With NPC_ALIGN_CHK_EN: F_PC=0x3004, and PC_Err=1 and stays 1 until reset.
  - Without: F_PC=0x3006 and PC_Err=0.
- Reset asserted together with stall=1 and a taken branch -> F_PC=0x3000 and PC_Err=0 at the next edge.
